tiny_processor_driver: RTL and testbench

//   FPGA-demo stimulus master for the tiny processor core. On request, holds the core in reset, then

---
 rtl/tiny_driver_pkg.sv | 28 ++
 rtl/tiny_processor_driver_sclk_gen.sv | 28 ++
 rtl/tiny_processor_driver.sv | 92 +++++++++
 tb/tb_tiny_processor_driver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_driver_pkg.sv
// tiny_driver_pkg: shared types, built-in program/data images and mode decode for the driver
package tiny_driver_pkg;
  typedef enum logic [1:0] {
    M_RUN       = 2'b00,
    M_LOAD_IMEM = 2'b01,
    M_LOAD_DMEM = 2'b10,
    M_HOLD      = 2'b11
  } mode_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CORE_RST,
    S_LOAD_I,
    S_LOAD_D,
    S_RUN,
    S_DONE
  } state_t;
  localparam logic [0:15][7:0] IMEM_ROM = {
    8'h81, 8'h42, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h5A, 8'hC3,
    8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'h01
  };
  localparam logic [0:15][7:0] DMEM_ROM = {
    8'h7E, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'hFF, 8'h00, 8'h55, 8'hAA, 8'h96, 8'h69, 8'hE7
  };
  function automatic mode_t mode_of(state_t s);
    return s == S_LOAD_I ? M_LOAD_IMEM : s == S_LOAD_D ? M_LOAD_DMEM : s == S_RUN ? M_RUN : M_HOLD;
  endfunction
endpackage

// File: rtl/tiny_processor_driver_sclk_gen.sv
// sclk_gen: divides clk into sclk_out and strobes fall_tick on the clk edge where sclk_out falls
module sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk_out,
  output logic fall_tick
);
  localparam int C_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [C_W-1:0] cnt;
  logic wrap;
  assign wrap = cnt == C_W'(CLK_DIV - 1);
  assign fall_tick = en && wrap && sclk_out;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      sclk_out <= 1'b0;
    end else if (!en) begin
      cnt      <= '0;
      sclk_out <= 1'b0;
    end else begin
      cnt      <= wrap ? '0 : cnt + 1'b1;
      sclk_out <= sclk_out ^ wrap;
    end
  end
endmodule

// File: rtl/tiny_processor_driver.sv
// tiny_processor_driver: resets the tiny core, serially loads IMEM/DMEM images, then runs it until done
module tiny_processor_driver
  import tiny_driver_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int RST_CYCLES = 4,
  parameter int WORDS      = 16,
  parameter int WORD_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       drive,
  input  logic       done_in,
  output logic       sclk_out,
  output logic       rst_n_out,
  output logic       mosi_out,
  output logic [1:0] mode_out
);
  localparam int B_W = $clog2(WORD_W);
  localparam int W_W = $clog2(WORDS);
  localparam int R_W = $clog2(RST_CYCLES + 1);
  state_t state, state_n;
  logic [B_W-1:0] bcnt, bcnt_n;
  logic [W_W-1:0] wcnt, wcnt_n;
  logic [R_W-1:0] rcnt, rcnt_n;
  logic [1:0] done_q;
  logic fall_tick, sclk_en, last_bit, mosi_n;
  assign sclk_en  = state != S_IDLE;
  assign last_bit = bcnt == '0 && wcnt == W_W'(WORDS - 1);
  sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (sclk_en),
    .sclk_out (sclk_out),
    .fall_tick(fall_tick)
  );
  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    wcnt_n  = wcnt;
    rcnt_n  = rcnt;
    case (state)
      S_IDLE: if (drive) begin
        state_n = S_CORE_RST;
        rcnt_n  = '0;
      end
      S_CORE_RST: if (fall_tick) begin
        rcnt_n = rcnt + 1'b1;
        if (rcnt == R_W'(RST_CYCLES - 1)) begin
          state_n = S_LOAD_I;
          bcnt_n  = B_W'(WORD_W - 1);
          wcnt_n  = '0;
        end
      end
      S_LOAD_I, S_LOAD_D: if (fall_tick) begin
        bcnt_n = bcnt == '0 ? B_W'(WORD_W - 1) : bcnt - 1'b1;
        wcnt_n = bcnt == '0 ? wcnt + 1'b1 : wcnt;
        if (last_bit) begin
          state_n = state == S_LOAD_I ? S_LOAD_D : S_RUN;
          bcnt_n  = B_W'(WORD_W - 1);
          wcnt_n  = '0;
        end
      end
      S_RUN:   if (fall_tick && done_q[1]) state_n = S_DONE;
      S_DONE:  if (fall_tick && !drive) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    mosi_n = state_n == S_LOAD_I ? IMEM_ROM[wcnt_n][bcnt_n] :
             state_n == S_LOAD_D ? DMEM_ROM[wcnt_n][bcnt_n] : 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bcnt      <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      done_q    <= '0;
      mosi_out  <= 1'b0;
      mode_out  <= M_HOLD;
      rst_n_out <= 1'b0;
    end else begin
      state     <= state_n;
      bcnt      <= bcnt_n;
      wcnt      <= wcnt_n;
      rcnt      <= rcnt_n;
      done_q    <= {done_q[0], done_in};
      mosi_out  <= mosi_n;
      mode_out  <= mode_of(state_n);
      rst_n_out <= !(state_n inside {S_IDLE, S_CORE_RST});
    end
  end
endmodule

// File: tb/tb_tiny_processor_driver.sv
// tb_tiny_processor_driver: directed self-checking bench for the tiny core load/run driver
module tb_tiny_processor_driver;
  logic clk = 1'b0, rst_n = 1'b0, drive = 1'b0, done_in = 1'b0;
  logic sclk_out, rst_n_out, mosi_out;
  logic [1:0] mode_out;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] imem [16] = '{8'h81, 8'h42, 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h5A, 8'hC3,
                            8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'h01};
  logic [7:0] dmem [16] = '{8'h7E, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                            8'h80, 8'hFF, 8'h00, 8'h55, 8'hAA, 8'h96, 8'h69, 8'hE7};
  always #5 clk = ~clk;
  tiny_processor_driver dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .drive    (drive),
    .done_in  (done_in),
    .sclk_out (sclk_out),
    .rst_n_out(rst_n_out),
    .mosi_out (mosi_out),
    .mode_out (mode_out)
  );
  task automatic wait_rise(output int n);
    logic p;
    p = sclk_out;
    n = -1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (!p && sclk_out) begin
        n = i;
        break;
      end
      p = sclk_out;
    end
  endtask
  task automatic wait_fall(output int n);
    logic p;
    p = sclk_out;
    n = -1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (p && !sclk_out) begin
        n = i;
        break;
      end
      p = sclk_out;
    end
  endtask
  task automatic get_word(input logic [1:0] m, output logic [7:0] w, output int bad);
    int n;
    bad = 0;
    w = '0;
    for (int b = 0; b < 8; b++) begin
      wait_rise(n);
      if (n < 0 || mode_out !== m || rst_n_out !== 1'b1) bad++;
      w = {w[6:0], mosi_out};
    end
  endtask
  task automatic test_reset;
    int hi;
    rst_n = 1'b0;
    drive = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({sclk_out, rst_n_out, mosi_out, mode_out} !== 5'b00011) begin
      n_bad++;
      $display("FAIL reset_vals got %b want 00011", {sclk_out, rst_n_out, mosi_out, mode_out});
    end
    rst_n = 1'b1;
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (sclk_out !== 1'b0 || rst_n_out !== 1'b0 || mode_out !== 2'b11) hi++;
    end
    n_cmp++;
    if (hi != 0) begin
      n_bad++;
      $display("FAIL idle_quiet got %0d active cycles want 0", hi);
    end
  endtask
  task automatic test_core_rst;
    int n;
    drive = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wait_rise(n);
      if (r > 0) begin
        n_cmp++;
        if (n !== 4) begin
          n_bad++;
          $display("FAIL sclk_period rise %0d got %0d want 4", r, n);
        end
      end
      n_cmp++;
      if (rst_n_out !== 1'b0 || mode_out !== 2'b11) begin
        n_bad++;
        $display("FAIL core_rst rise %0d got rst=%b mode=%b want rst=0 mode=11", r, rst_n_out, mode_out);
      end
    end
  endtask
  task automatic test_load_i(input int drop_at);
    logic [7:0] w;
    int bad, n;
    for (int i = 0; i < 16; i++) begin
      get_word(2'b01, w, bad);
      if (i == drop_at) drive = 1'b0;
      n_cmp++;
      if (w !== imem[i] || bad != 0) begin
        n_bad++;
        $display("FAIL imem_word %0d got %h (bad=%0d) want %h", i, w, bad, imem[i]);
      end
    end
    wait_fall(n);
    n_cmp++;
    if (n < 0 || mode_out !== 2'b10) begin
      n_bad++;
      $display("FAIL to_load_d got mode=%b n=%0d want 10", mode_out, n);
    end
  endtask
  task automatic test_load_d;
    logic [7:0] w;
    int bad, n;
    for (int i = 0; i < 16; i++) begin
      get_word(2'b10, w, bad);
      n_cmp++;
      if (w !== dmem[i] || bad != 0) begin
        n_bad++;
        $display("FAIL dmem_word %0d got %h (bad=%0d) want %h", i, w, bad, dmem[i]);
      end
    end
    wait_fall(n);
    n_cmp++;
    if (n < 0 || mode_out !== 2'b00 || mosi_out !== 1'b0) begin
      n_bad++;
      $display("FAIL to_run got mode=%b mosi=%b n=%0d want mode=00 mosi=0", mode_out, mosi_out, n);
    end
  endtask
  task automatic test_done;
    int k, n;
    done_in = 1'b1;
    k = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mode_out === 2'b11) begin
        k = i;
        break;
      end
    end
    done_in = 1'b0;
    n_cmp++;
    if (k < 0 || k > 7 || rst_n_out !== 1'b1) begin
      n_bad++;
      $display("FAIL done_latency got %0d clk rst=%b want 1..7 rst=1", k, rst_n_out);
    end
    wait_rise(n);
    n_cmp++;
    if (n > 4 || n < 1 || mode_out !== 2'b11 || rst_n_out !== 1'b1) begin
      n_bad++;
      $display("FAIL done_toggle got n=%0d mode=%b rst=%b want n<=4 mode=11 rst=1", n, mode_out, rst_n_out);
    end
  endtask
  task automatic test_idle_return;
    int k, hi;
    drive = 1'b0;
    k = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sclk_out === 1'b0 && rst_n_out === 1'b0) begin
        k = i;
        break;
      end
    end
    hi = 0;
    repeat (12) begin
      @(negedge clk);
      if (sclk_out !== 1'b0 || rst_n_out !== 1'b0 || mode_out !== 2'b11) hi++;
    end
    n_cmp++;
    if (k < 0 || hi != 0) begin
      n_bad++;
      $display("FAIL idle_return got k=%0d active=%0d want k>=1 active=0", k, hi);
    end
  endtask
  task automatic test_drive_drop;
    int n;
    drive = 1'b1;
    repeat (4) wait_rise(n);
    test_load_i(1);
    test_load_d;
  endtask
  task automatic test_reset_mid;
    int n, bad;
    logic [7:0] w;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive = 1'b1;
    repeat (4) wait_rise(n);
    repeat (37) wait_rise(n);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sclk_out, rst_n_out, mosi_out, mode_out} !== 5'b00011) begin
      n_bad++;
      $display("FAIL reset_mid got %b want 00011", {sclk_out, rst_n_out, mosi_out, mode_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) wait_rise(n);
    for (int i = 0; i < 2; i++) begin
      get_word(2'b01, w, bad);
      n_cmp++;
      if (w !== imem[i] || bad != 0) begin
        n_bad++;
        $display("FAIL restart_word %0d got %h (bad=%0d) want %h", i, w, bad, imem[i]);
      end
    end
  endtask
  initial begin
    test_reset;
    test_core_rst;
    test_load_i(99);
    test_load_d;
    test_done;
    test_idle_return;
    test_drive_drop;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
